// File: rtl/sha256_block_feeder_pkg.sv
// ============================================================================
// Package     : sha256_pkg
// Description : Types and constants shared by the SHA-256 block feeder and
//               the compression core: the message word type, block geometry,
//               the padding marker word and the feeder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int    WORDS_PER_BLOCK = 16;
    localparam word_t PAD_WORD        = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

    // Reverse the byte order of a word (big-endian <-> little-endian view).
    function automatic word_t byte_swap(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_block_feeder_if.sv
// ============================================================================
// Interface   : sha256_block_feeder_if
// Description : Word stream from the block feeder to the compression core.
//               One padded message word moves per out_valid && out_ready.
//   out_valid  master->slave  out_word and flags are valid
//   out_ready  slave->master  downstream accepts the word
//   out_word   master->slave  padded message word
//   out_first  master->slave  word is index 0 of its block
//   out_last   master->slave  word is index 15 of its block
//   out_final  master->slave  word belongs to the final block
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sha256_block_feeder_if;
    import sha256_pkg::*;

    logic  out_valid;
    logic  out_ready;
    word_t out_word;
    logic  out_first;
    logic  out_last;
    logic  out_final;

    modport master (
        output out_valid,
        output out_word,
        output out_first,
        output out_last,
        output out_final,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_word,
        input  out_first,
        input  out_last,
        input  out_final,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/sha256_block_feeder_skid_buf.sv
// ============================================================================
// Module      : sha256_skid_buf
// Description : 2-entry valid/ready FIFO. The head entry drives the output and
//               only changes when it is popped, so the output is stable while
//               stalled. The writer must not push into a full buffer unless
//               the head is popped in the same cycle.
//   clk      in   clock
//   reset_n  in   synchronous active-low reset (empties the buffer)
//   push_i   in   write data_i this cycle
//   data_i   in   WIDTH-bit entry to write
//   valid_o  out  head entry is valid
//   data_o   out  head entry
//   ready_i  in   consumer takes the head entry
//   count_o  out  number of occupied entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_skid_buf #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             w_pop;

    assign w_pop = (count_q != 2'd0) && ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push_i) begin
                    head_d  = data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && w_pop) begin
                    head_d = data_i;
                end else if (push_i) begin
                    tail_d  = data_i;
                    count_d = 2'd2;
                end else if (w_pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (w_pop) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = data_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/sha256_block_feeder.sv
// ============================================================================
// Module      : sha256_block_feeder
// Description : Reads a message from word-addressed memory, appends SHA-256
//               padding (0x8000_0000 marker, zero fill, 64-bit bit length)
//               and streams the result as 16-word blocks.
//   clk            in   clock (also forwarded as mem_clk)
//   reset_n        in   synchronous active-low reset
//   start          in   request, sampled only in IDLE
//   message_addr   in   first message word address, latched on start
//   msg_words      in   message length in words, latched on start
//   done           out  high while idle
//   mem_clk        out  memory clock (= clk)
//   mem_we         out  constant 0
//   mem_addr       out  read address; data returns one cycle later
//   mem_read_data  in   data for the address presented the previous cycle
//   out_if         master side of the padded word stream
// Optional macro : SHA256_FEEDER_BYTESWAP_EN - byte-reverse memory words
//                  (never pad/length words); timing is unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_block_feeder
    import sha256_pkg::*;
#(
    parameter int MAX_WORDS = 1024,
    parameter int ADDR_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     message_addr,
    input  logic [15:0]           msg_words,
    output logic                  done,
    output logic                  mem_clk,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    input  word_t                 mem_read_data,
    sha256_block_feeder_if.master out_if
);

    localparam logic [15:0] c_MAX_WORDS = 16'(MAX_WORDS);

    feeder_state_t     state_q;
    logic              done_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       words_q;
    logic [16:0]       total_q;
    logic [16:0]       k_q;

    // One-deep issue stage: every word (memory or pad) spends exactly one
    // cycle here so that both kinds reach the buffer with the same latency.
    logic              inf_valid_q;
    logic              inf_mem_q;
    word_t             inf_pad_q;
    logic              inf_first_q;
    logic              inf_last_q;
    logic              inf_final_q;

    logic [15:0]       w_clamp;
    logic [16:0]       w_total;
    logic              w_is_mem;
    word_t             w_pad_word;
    word_t             w_mem_word;
    logic              w_first;
    logic              w_last;
    logic              w_final;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_buf_valid;
    logic [34:0]       w_buf_data;
    logic [1:0]        w_buf_count;
    logic              w_pop;
    logic [2:0]        w_used;
    logic              w_issue;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;
    assign done    = done_q;

    assign w_clamp = (msg_words > c_MAX_WORDS) ? c_MAX_WORDS : msg_words;
    // T = 16 * (((W + 2) >> 4) + 1): room for the marker word and the two
    // length words.
    assign w_total = ((((17'(w_clamp) + 17'd2) >> 4) + 17'd1) << 4);

    assign w_is_mem    = (k_q < {1'b0, words_q});
    assign w_addr_next = base_q + ADDR_W'(k_q);
    assign w_first     = (k_q[3:0] == 4'd0);
    assign w_last      = (k_q[3:0] == 4'hF);
    assign w_final     = (k_q >= (total_q - 17'd16));

    // The length high word (index T-2) is always zero for a 16-bit count.
    always_comb begin
        w_pad_word = '0;
        if (k_q == {1'b0, words_q}) begin
            w_pad_word = PAD_WORD;
        end else if (k_q == (total_q - 17'd1)) begin
            w_pad_word = {11'd0, words_q, 5'd0};
        end
    end

`ifdef SHA256_FEEDER_BYTESWAP_EN
    assign w_mem_word = byte_swap(mem_read_data);
`else
    assign w_mem_word = mem_read_data;
`endif

    // Occupancy the buffer will have after this edge, counting the word in
    // the issue stage. A new issue lands one edge later, so staying below 2
    // can never overflow the buffer, yet keeps one word per cycle flowing.
    assign w_pop   = w_buf_valid && out_if.out_ready;
    assign w_used  = {1'b0, w_buf_count} - {2'b00, w_pop} + {2'b00, inf_valid_q};
    assign w_issue = (state_q == RUN) && (k_q < total_q) && (w_used < 3'd2);

    // The address is presented in the issue cycle so the memory samples it
    // at the next edge and the data is captured one edge after that.
    assign mem_addr = (w_issue && w_is_mem) ? w_addr_next : addr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            done_q      <= 1'b1;
            base_q      <= '0;
            addr_q      <= '0;
            words_q     <= '0;
            total_q     <= '0;
            k_q         <= '0;
            inf_valid_q <= 1'b0;
            inf_mem_q   <= 1'b0;
            inf_pad_q   <= '0;
            inf_first_q <= 1'b0;
            inf_last_q  <= 1'b0;
            inf_final_q <= 1'b0;
        end else begin
            inf_valid_q <= w_issue;
            if (w_issue) begin
                inf_mem_q   <= w_is_mem;
                inf_pad_q   <= w_pad_word;
                inf_first_q <= w_first;
                inf_last_q  <= w_last;
                inf_final_q <= w_final;
                k_q         <= k_q + 17'd1;
                if (w_is_mem) begin
                    addr_q <= w_addr_next;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q  <= message_addr;
                        addr_q  <= message_addr;
                        words_q <= w_clamp;
                        total_q <= w_total;
                        k_q     <= '0;
                        done_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (w_issue && (k_q == (total_q - 17'd1))) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((w_buf_count == 2'd0) && !inf_valid_q) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sha256_skid_buf #(
        .WIDTH (35)
    ) u_skid_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (inf_valid_q),
        .data_i  ({(inf_mem_q ? w_mem_word : inf_pad_q),
                   inf_first_q, inf_last_q, inf_final_q}),
        .valid_o (w_buf_valid),
        .data_o  (w_buf_data),
        .ready_i (out_if.out_ready),
        .count_o (w_buf_count)
    );

    assign out_if.out_valid = w_buf_valid;
    assign out_if.out_word  = w_buf_data[34:3];
    assign out_if.out_first = w_buf_data[2];
    assign out_if.out_last  = w_buf_data[1];
    assign out_if.out_final = w_buf_data[0];

endmodule

`default_nettype wire

// File: tb/tb_sha256_block_feeder.sv
// ============================================================================
// Module      : tb_sha256_block_feeder
// Description : Self-checking bench for sha256_block_feeder. A reference
//               model builds the expected padded stream per message; a
//               monitor compares every accepted word, output stability while
//               stalled, and start-to-word timing when ready is held high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_block_feeder;
    import sha256_pkg::*;

    localparam int              ADDR_W = 16;
    localparam logic [15:0]     BASE   = 16'h0040;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] message_addr;
    logic [15:0]       msg_words;
    logic              done;
    logic              mem_clk;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    word_t             mem_read_data;

    always #5 clk = ~clk;

    sha256_block_feeder_if u_if ();

    sha256_block_feeder #(
        .MAX_WORDS (1024),
        .ADDR_W    (ADDR_W)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .message_addr  (message_addr),
        .msg_words     (msg_words),
        .done          (done),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_read_data (mem_read_data),
        .out_if        (u_if)
    );

    // Synchronous-read memory: word at BASE+i holds i+1.
    word_t mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) - 32'(BASE) + 32'd1;
    end
    always @(posedge clk) mem_read_data <= mem[mem_addr[7:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic word_t model_mem_word(input int k);
        word_t v;
        v = 32'(k + 1);
`ifdef SHA256_FEEDER_BYTESWAP_EN
        v = {v[7:0], v[15:8], v[23:16], v[31:24]};
`endif
        return v;
    endfunction

    function automatic word_t model_word(input int w, input int k, input int t);
        if (k < w)          return model_mem_word(k);
        else if (k == w)    return 32'h8000_0000;
        else if (k == t-1)  return 32'(w * 32);
        else                return 32'h0;
    endfunction

    logic [34:0] exp_arr [0:63];
    logic [34:0] cap     [0:63];
    int          exp_t     = 0;
    int          idx       = 0;
    int          start_cyc = 0;
    bit          active    = 0;
    bit          nobubble  = 0;
    bit          rand_ready = 0;
    bit          addr_chk  = 0;
    bit          addr_bad  = 0;
    logic [15:0] addr_lo, addr_hi;
    bit          prev_stall = 0;
    logic [34:0] prev_beat;
    logic [34:0] mon_beat;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        mon_beat = {u_if.out_word, u_if.out_first, u_if.out_last, u_if.out_final};
        if (active) begin
            if (prev_stall)
                check($sformatf("stall_hold[%0d]", idx), {29'd0, u_if.out_valid, mon_beat},
                      {29'd0, 1'b1, prev_beat});
            if (u_if.out_valid && u_if.out_ready) begin
                if (idx >= exp_t) begin
                    check("extra_word_index", 64'(idx), 64'(exp_t - 1));
                end else begin
                    check($sformatf("word[%0d]", idx), 64'(mon_beat), 64'(exp_arr[idx]));
                    if (nobubble)
                        check($sformatf("timing[%0d]", idx), 64'(cyc), 64'(start_cyc + 2 + idx));
                    cap[idx] = mon_beat;
                    idx++;
                end
            end
            prev_stall = u_if.out_valid && !u_if.out_ready;
            prev_beat  = mon_beat;
        end else begin
            prev_stall = 0;
        end
        if (addr_chk && ((mem_addr < addr_lo) || (mem_addr > addr_hi))) addr_bad = 1;
    end

    // ---------------- downstream ready driver ----------------
    initial begin
        void'($urandom(1));
        u_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            u_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- scenario runner ----------------
    task automatic run(input int w, input bit rnd, input int abort_at, input bit glitch);
        int nb;
        int t;
        int lim;
        nb = 1;
        while (nb * 16 < w + 3) nb++;
        t = nb * 16;
        for (int k = 0; k < t; k++)
            exp_arr[k] = {model_word(w, k, t), (k % 16) == 0, (k % 16) == 15, k >= t - 16};
        for (int k = 0; k < 64; k++) cap[k] = '0;
        exp_t      = t;
        idx        = 0;
        rand_ready = rnd;
        nobubble   = !rnd;
        lim        = (abort_at >= 0) ? abort_at : t;

        @(posedge clk);
        #1;
        start        = 1'b1;
        message_addr = BASE;
        msg_words    = 16'(w);
        @(posedge clk);
        #1;
        start        = 1'b0;
        message_addr = 16'hFFFF;
        msg_words    = 16'd5;
        start_cyc    = cyc;
        addr_lo      = BASE;
        addr_hi      = BASE + 16'((w > 0) ? w - 1 : 0);
        addr_bad     = 0;
        addr_chk     = 1;
        active       = 1;

        for (int c = 0; c < 2000 && idx < lim; c++) begin
            if (glitch && c == 5) begin
                start        = 1'b1;
                msg_words    = 16'd3;
                message_addr = 16'h0000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check($sformatf("stream_len_w%0d", w), 64'(idx), 64'(lim));

        if (abort_at >= 0) begin
            active   = 0;
            addr_chk = 0;
            reset_n  = 1'b0;
            @(posedge clk);
            #1;
            check("abort_out_valid", 64'(u_if.out_valid), 64'd0);
            check("abort_done", 64'(done), 64'd1);
            check("abort_mem_addr", 64'(mem_addr), 64'd0);
            reset_n    = 1'b1;
            rand_ready = 0;
        end else begin
            for (int c = 0; c < 50 && !done; c++) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("done_w%0d", w), 64'(done), 64'd1);
            check($sformatf("addr_range_w%0d", w), 64'(addr_bad), 64'd0);
            if (w > 0)
                check($sformatf("addr_hold_w%0d", w), 64'(mem_addr), 64'(BASE + 16'(w - 1)));
            active     = 0;
            addr_chk   = 0;
            rand_ready = 0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        message_addr = '0;
        msg_words    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(u_if.out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd1);
        check("rst_out_word", 64'(u_if.out_word), 64'd0);
        check("rst_flags", 64'({u_if.out_first, u_if.out_last, u_if.out_final}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);

        // W=20: two blocks, ready held high.
        run(20, 0, -1, 0);
        check("w20_word20", 64'(cap[20][34:3]), 64'h8000_0000);
        check("w20_word31", 64'(cap[31][34:3]), 64'h0000_0280);
        check("w20_word25", 64'(cap[25][34:3]), 64'h0);
        check("w20_first16", 64'(cap[16][2]), 64'd1);
        check("w20_last15", 64'(cap[15][1]), 64'd1);
        check("w20_final15", 64'(cap[15][0]), 64'd0);
        check("w20_final16", 64'(cap[16][0]), 64'd1);

        // W=13: single block.
        run(13, 0, -1, 0);
        check("w13_word13", 64'(cap[13][34:3]), 64'h8000_0000);
        check("w13_word15", 64'(cap[15][34:3]), 64'h0000_01A0);
        check("w13_final0", 64'(cap[0][0]), 64'd1);

        // W=14: marker lands at 14, length spills into a second block.
        run(14, 0, -1, 0);
        check("w14_word14", 64'(cap[14][34:3]), 64'h8000_0000);
        check("w14_word15", 64'(cap[15][34:3]), 64'h0);
        check("w14_word30", 64'(cap[30][34:3]), 64'h0);
        check("w14_word31", 64'(cap[31][34:3]), 64'h0000_01C0);

        // W=0: marker only.
        run(0, 0, -1, 0);
        check("w0_word0", 64'(cap[0][34:3]), 64'h8000_0000);
        check("w0_word15", 64'(cap[15][34:3]), 64'h0);

        // W=20 with random backpressure.
        run(20, 1, -1, 0);
        check("w20r_word20", 64'(cap[20][34:3]), 64'h8000_0000);
        check("w20r_word31", 64'(cap[31][34:3]), 64'h0000_0280);

        // Reset at word 9, then a fresh run with an ignored start pulse.
        run(20, 0, 9, 0);
        @(posedge clk);
        run(20, 0, -1, 1);
        check("w20g_word31", 64'(cap[31][34:3]), 64'h0000_0280);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/sha256_block_feeder.md
Name: sha256_block_feeder

Overview:
- Upstream stage of the SHA-256 compression core.
- On `start`, reads `msg_words` 32-bit words from word-addressed memory beginning at `message_addr`, then appends standard SHA-256 padding.
- Streams the padded message as consecutive 16-word blocks over a valid/ready word interface.
- Padding and block counting are removed from the compressor; it consumes one W word per handshake.

Parameters:
- `MAX_WORDS`, default 1024: largest accepted `msg_words`. Larger requests are clamped to `MAX_WORDS`.
- `ADDR_W`, default 16: memory address width.

Ports:
- `clk`  in  1  single clock; `mem_clk` is driven from it.
- `reset_n`  in  1  synchronous active-low reset.
- `start`  in  1  one-cycle request, sampled only in IDLE.
- `message_addr`  in  ADDR_W  first message word address, latched on start.
- `msg_words`  in  16  message length in 32-bit words, latched on start.
- `done`  out  1  high while in IDLE.
- `mem_clk`  out  1  equals `clk`.
- `mem_we`  out  1  constant 0 (read-only master).
- `mem_addr`  out  ADDR_W  read address.
- `mem_read_data`  in  32  data for the address presented in the previous cycle.
- `out_valid`  out  1  `out_word` is valid.
- `out_ready`  in  1  downstream accepts a word.
- `out_word`  out  32  padded message word.
- `out_first`  out  1  word is index 0 of a block.
- `out_last`  out  1  word is index 15 of a block.
- `out_final`  out  1  word belongs to the final block.

Behaviour:
- Reset (`reset_n` low at a `clk` edge):
  - state=IDLE; `done`=1; `out_valid`=0; `out_word`/`out_first`/`out_last`/`out_final`=0; `mem_addr`=0; `mem_we`=0.
  - Skid buffer emptied; in-flight read discarded.
  - Reset mid-stream aborts the message; the downstream must treat a missing `out_last` as abort.
- Block count: latched W = min(`msg_words`, `MAX_WORDS`); NB = ((W+2)>>4)+1; total words T = NB*16.
  - W=13 → NB=1; W=14 → NB=2; W=20 → NB=2; W=0 → NB=1.
- Word index k runs 0..T-1. Source of word k:
  - k<W: mem[`message_addr`+k].
  - k==W: 32'h8000_0000.
  - k==T-2: length high word = (W*32)>>32, which is always 0 for 16-bit W.
  - k==T-1: length low word = W<<5, truncated to 32 bits.
  - Otherwise 0.
- States:
  - IDLE: `start`=1 → latch inputs, k=0 → RUN.
  - RUN: issue reads / generate pad words → DRAIN once the last word has entered the buffer.
  - DRAIN: wait until the buffer is empty → IDLE.
- Memory read latency is exactly 1 cycle. A read is issued only when buffer occupancy + in-flight reads < 2.
- Pad words are inserted directly and take no memory cycle.
- Output buffer:
  - 2-entry skid buffer; a word transfers when `out_valid` && `out_ready`.
  - Output fields must not change while `out_valid`=1 and `out_ready`=0.
- Throughput: with `out_ready` held high, the first word appears 2 cycles after the `start` edge; thereafter one word per cycle, no bubbles, including across the memory→padding boundary and across block boundaries.
- Flags are computed from k: `out_first` = (k%16==0); `out_last` = (k%16==15); `out_final` = (k>=T-16).
- `start` while not IDLE: ignored.
- `start` in the same cycle `done` rises: accepted on the next cycle only.
- `mem_addr` after the final memory read: holds the last issued address.

Optional Feature:
- Macro: `SHA256_FEEDER_BYTESWAP_EN`.
- Defined: every word read from memory is byte-reversed before buffering, e.g. 32'h0102_0304 → 32'h0403_0201. Pad and length words are never swapped.
- Undefined: memory words pass through unchanged.
- Latency and throughput are identical in both cases.

Decomposition:
- Package `sha256_pkg`:
  - `word_t` (logic [31:0]).
  - `WORDS_PER_BLOCK`=16.
  - `PAD_WORD`=32'h8000_0000.
  - Feeder state enum {IDLE, RUN, DRAIN}.
  - Shared with the compressor.
- One sub-module: `sha256_skid_buf`, a 2-entry valid/ready buffer carrying 35 bits (word + first/last/final).

Test Plan:
- W=20, `out_ready`=1, memory word i = i+1 → 32 words, no bubbles. Word 20 = 8000_0000; words 21..30 = 0; word 31 = 0000_0280. `out_first` at words 0 and 16; `out_final` on words 16..31.
- W=13 → single block: words 0..12 = memory, word 13 = 8000_0000, word 14 = 0, word 15 = 0000_01A0; `out_final` on all 16 words.
- W=14 → two blocks: word 14 = 8000_0000; words 15..29 = 0; word 30 = 0; word 31 = 0000_01C0.
- W=0 → one block: word 0 = 8000_0000, words 1..15 = 0; no memory address issued beyond `message_addr`.
- W=20 with `out_ready` toggling pseudo-randomly (seed 1) → word sequence identical to the first scenario; outputs held stable while stalled.
- `reset_n` low at word 9 of the first scenario → next cycle `out_valid`=0, `done`=1. A fresh start then streams correctly from word 0. A `start` pulse during RUN is ignored.
